// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract controller.
// Two requesters share one 1-bit add/subtract cell through a round-robin arbiter.
// Operands are streamed through the cell LSB-first over WIDTH cycles.
// Optional feature macro: SERIAL_OVF_EN. When it is defined, the carry into the
// MSB is kept and signed overflow is reported. When it is undefined, ovf stays 0.

// 1-bit add/subtract cell: sel=1 inverts b so that a-b = a + ~b + 1.
// The +1 enters through Cin. In gate-delay simulation the Sum path can take
// up to 35 ns, so the clock period must be at least 50 ns.
module FullAdder_1_bit (
  input  logic a,
  input  logic b,
  input  logic sel,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  logic bx;

  // Conditional inversion of b, followed by a plain full adder.
  always_comb begin
    bx   = b ^ sel;
    Sum  = a ^ bx ^ Cin;
    Cout = (a & bx) | (Cin & (a ^ bx));
  end
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sel0,
  input  logic             sel1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             ptr;      // last-served requester
  logic             served;   // requester of the in-flight operation
  logic             sel_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sh;   // shift register that collects the result bits
`ifdef SERIAL_OVF_EN
  logic             cmsb;     // carry into the MSB
`endif

  logic             any_req;
  logic             winner;
  logic             sum_w;
  logic             cout_w;
  logic [WIDTH-1:0] res_next;

  // Round-robin pick: on a tie, the requester that was not served last wins.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) winner = ~ptr;
    else              winner = req1;
  end

  FullAdder_1_bit u_cell (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .sel  (sel_q),
    .Cin  (carry),
    .Sum  (sum_w),
    .Cout (cout_w)
  );

  // Next value of the result shifter: the new sum bit enters at the MSB.
  always_comb begin
    res_next = {sum_w, res_sh[WIDTH-1:1]};
  end

  // Control FSM with registered outputs.
  // The visible result is loaded only at the last shift, so it holds between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b1;
      served  <= 1'b0;
      sel_q   <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_sh  <= '0;
`ifdef SERIAL_OVF_EN
      cmsb    <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a   <= winner ? a1 : a0;
            op_b   <= winner ? b1 : b0;
            sel_q  <= winner ? sel1 : sel0;
            carry  <= winner ? sel1 : sel0;
            cnt    <= '0;
            served <= winner;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_sh <= res_next;
          op_a   <= op_a >> 1;
          op_b   <= op_b >> 1;
          carry  <= cout_w;
          cnt    <= cnt + CW'(1);
`ifdef SERIAL_OVF_EN
          if (cnt == CW'(WIDTH - 2)) cmsb <= cout_w;
`endif
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= served;
            result  <= res_next;
            cout    <= cout_w;
`ifdef SERIAL_OVF_EN
            ovf     <= cout_w ^ cmsb;
`else
            ovf     <= 1'b0;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ptr   <= served;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
